// File: rtl/g_sipo_pkg.sv
// g_sipo_pkg: shared definitions for the g_sipo_rx serial receiver.
//   - state encoding for the shift FSM (ST_PAR is only reached when
//     G_SIPO_RX_PARITY_EN is defined)
//   - clog2 helper used to size the bit counter
//   - default word width
package g_sipo_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/g_sipo_outreg.sv
// g_sipo_outreg: parallel output holding register with valid/ready flow
// control and a sticky overrun flag.
//   CLK        rising-edge clock
//   RSTN       synchronous active-low reset
//   word_done  a complete word is offered this cycle
//   word_data  the completed word
//   word_perr  parity error for the completed word
//   POR        consumer ready
//   CLR        clears OVR (a same-cycle overrun wins)
//   PO/POV     registered word and its valid flag
//   OVR        sticky overrun: a word completed while PO was still unread
//   PERR       parity error registered alongside PO
module g_sipo_outreg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             word_done,
    input  logic [WIDTH-1:0] word_data,
    input  logic             word_perr,
    input  logic             POR,
    input  logic             CLR,
    output logic [WIDTH-1:0] PO,
    output logic             POV,
    output logic             OVR,
    output logic             PERR
);

    logic load_word;
    logic overrun;

    // A slot is free when nothing is pending or the pending word is taken
    // this very cycle, so a handshake and a completion can overlap.
    assign load_word = word_done && (!POV || POR);
    assign overrun   = word_done && POV && !POR;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            PO   <= '0;
            POV  <= 1'b0;
            PERR <= 1'b0;
            OVR  <= 1'b0;
        end else begin
            if (load_word) begin
                PO   <= word_data;
                PERR <= word_perr;
                POV  <= 1'b1;
            end else if (POV && POR) begin
                POV  <= 1'b0;
            end

            if (overrun) begin
                OVR <= 1'b1;
            end else if (CLR) begin
                OVR <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/g_sipo_rx.sv
// g_sipo_rx: serial-to-parallel receiver. Collects one qualified bit per
// clock into WIDTH-bit words and hands them to g_sipo_outreg.
//   CLK   rising-edge clock
//   RSTN  synchronous active-low reset
//   SI    serial data, consumed only when SIV=1
//   SIV   SI qualifier
//   SOF   start of frame (only meaningful with SIV=1)
//   POR   consumer ready
//   CLR   clears OVR
//   PO    parallel word, POV its valid flag
//   OVR   sticky overrun flag
//   PERR  parity error for the word on PO (0 unless parity is enabled)
// Build option: define G_SIPO_RX_PARITY_EN to expect an even-parity bit
// after each word; the port list is the same either way.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for SIV=1 with SOF=1
// ST_SHIFT | collecting data bits, cnt = bits received so far
// ST_PAR   | all data bits in, waiting for the parity bit
module g_sipo_rx
    import g_sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             SI,
    input  logic             SIV,
    input  logic             SOF,
    input  logic             POR,
    input  logic             CLR,
    output logic [WIDTH-1:0] PO,
    output logic             POV,
    output logic             OVR,
    output logic             PERR
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] shifted, fresh;
    logic             word_done;
    logic [WIDTH-1:0] word_data;
    logic             word_perr;

    // fresh starts a word from zero so an abandoned frame leaves no residue.
    assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], SI} : {SI, sreg[WIDTH-1:1]};
    assign fresh   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, SI} : {SI, {(WIDTH-1){1'b0}}};

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        case (state)
            ST_IDLE: begin
                if (SIV && SOF) begin
                    sreg_nxt  = fresh;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (SIV) begin
                    if (SOF) begin
                        sreg_nxt = fresh;
                        cnt_nxt  = CNT_ONE;
                    end else begin
                        sreg_nxt = shifted;
                        if (cnt == CNT_LAST) begin
                            cnt_nxt = '0;
`ifdef G_SIPO_RX_PARITY_EN
                            state_nxt = ST_PAR;
`else
                            state_nxt = ST_IDLE;
`endif
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                end
            end
`ifdef G_SIPO_RX_PARITY_EN
            ST_PAR: begin
                // SOF is deliberately not honoured here: the bit is parity.
                if (SIV) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        word_done = 1'b0;
        word_data = shifted;
        word_perr = 1'b0;
        case (state)
`ifdef G_SIPO_RX_PARITY_EN
            ST_PAR: begin
                word_done = SIV;
                word_data = sreg;
                word_perr = (^sreg) ^ SI;
            end
`else
            ST_SHIFT: begin
                word_done = SIV && !SOF && (cnt == CNT_LAST);
            end
`endif
            default: word_done = 1'b0;
        endcase
    end

    g_sipo_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .word_done (word_done),
        .word_data (word_data),
        .word_perr (word_perr),
        .POR       (POR),
        .CLR       (CLR),
        .PO        (PO),
        .POV       (POV),
        .OVR       (OVR),
        .PERR      (PERR)
    );

endmodule

// File: tb/tb_g_sipo_rx.sv
`timescale 1ns/1ps
module tb_g_sipo_rx;

    localparam int W = 8;
`ifdef G_SIPO_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic SI = 1'b0;
    logic SIV = 1'b0;
    logic SOF = 1'b0;
    logic POR = 1'b0;
    logic CLR = 1'b0;

    logic [W-1:0] po_m, po_l;
    logic pov_m, pov_l, ovr_m, ovr_l, perr_m, perr_l;

    g_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .CLK(CLK), .RSTN(RSTN), .SI(SI), .SIV(SIV), .SOF(SOF), .POR(POR), .CLR(CLR),
        .PO(po_m), .POV(pov_m), .OVR(ovr_m), .PERR(perr_m)
    );

    g_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .RSTN(RSTN), .SI(SI), .SIV(SIV), .SOF(SOF), .POR(POR), .CLR(CLR),
        .PO(po_l), .POV(pov_l), .OVR(ovr_l), .PERR(perr_l)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits of the current frame in arrival order, words
    // formed from that list once it holds W entries.
    typedef struct {
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        logic         pe;
    } exp_t;

    bit   bits[$];
    bit   in_frame = 1'b0;
    bit   in_par = 1'b0;
    bit   m_pov = 1'b0;
    bit   m_ovr = 1'b0;
    exp_t exp_q[$];

    task automatic model_step();
        bit   done;
        bit   par_bit;
        bit   old_pov;
        exp_t e;
        done    = 1'b0;
        par_bit = 1'b0;
        old_pov = m_pov;
        if (!RSTN) begin
            bits.delete();
            in_frame = 1'b0;
            in_par   = 1'b0;
            m_pov    = 1'b0;
            m_ovr    = 1'b0;
            exp_q.delete();
            return;
        end
        if (SIV) begin
            if (in_par) begin
                par_bit = SI;
                in_par  = 1'b0;
                done    = 1'b1;
            end else begin
                if (SOF) begin
                    bits.delete();
                    bits.push_back(SI);
                    in_frame = 1'b1;
                end else if (in_frame) begin
                    bits.push_back(SI);
                end
                if (in_frame && bits.size() == W) begin
                    in_frame = 1'b0;
                    if (PAR_EN) in_par = 1'b1;
                    else        done   = 1'b1;
                end
            end
        end
        if (done) begin
            e.wm = '0;
            e.wl = '0;
            e.pe = par_bit;
            for (int i = 0; i < W; i++) begin
                e.wm[W-1-i] = bits[i];
                e.wl[i]     = bits[i];
                e.pe        = e.pe ^ bits[i];
            end
            if (!PAR_EN) e.pe = 1'b0;
        end
        if (done && (!old_pov || POR)) begin
            m_pov = 1'b1;
            exp_q.push_back(e);
        end else if (old_pov && POR) begin
            m_pov = 1'b0;
        end
        if (done && old_pov && !POR) m_ovr = 1'b1;
        else if (CLR)                m_ovr = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // Monitor: flags checked every cycle, a new word popped and compared
    // whenever the DUT presents one.
    bit mon_en = 1'b0;
    bit prev_pov = 1'b0;
    bit prev_por = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                check("pov_msb", 32'(pov_m), 32'(m_pov));
                check("pov_lsb", 32'(pov_l), 32'(m_pov));
                check("ovr_msb", 32'(ovr_m), 32'(m_ovr));
                check("ovr_lsb", 32'(ovr_l), 32'(m_ovr));
                if (pov_m && (!prev_pov || prev_por)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got PO=%0h expected no word at %0t", po_m, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("po_msb", 32'(po_m), 32'(e.wm));
                        check("po_lsb", 32'(po_l), 32'(e.wl));
                        check("perr_msb", 32'(perr_m), 32'(e.pe));
                        check("perr_lsb", 32'(perr_l), 32'(e.pe));
                    end
                end
                prev_pov = pov_m;
                prev_por = POR;
            end
        end
    end

    bit rand_mode = 1'b0;

    task automatic cyc();
        if (rand_mode) begin
            POR = 1'($urandom_range(0, 1));
            CLR = ($urandom_range(0, 15) == 0);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        SIV = 1'b0;
        SOF = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic gap_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            SIV = 1'b0;
            SOF = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            SI  = 1'($urandom_range(0, 1));
            cyc();
        end
        SOF = 1'b0;
    endtask

    // Sends d first-bit-first from d[W-1], followed by a parity bit when
    // parity is enabled. last_por >= 0 forces POR on the completing cycle.
    task automatic send_word(input logic [W-1:0] d, input int gap, input int last_por,
                             input bit last_clr, input bit bad_par);
        int  nb;
        bit  saved_por;
        nb = W + (PAR_EN ? 1 : 0);
        for (int i = 0; i < nb; i++) begin
            if (i != 0) gap_cycles(gap);
            SIV = 1'b1;
            SOF = (i == 0);
            SI  = (i < W) ? d[W-1-i] : ((^d) ^ bad_par);
            saved_por = POR;
            if (i == nb - 1) begin
                if (last_por >= 0) POR = last_por[0];
                if (last_clr)      CLR = 1'b1;
            end
            cyc();
            if (i == nb - 1) begin
                if (last_por >= 0) POR = saved_por;
                if (last_clr)      CLR = 1'b0;
            end
        end
        SIV = 1'b0;
        SOF = 1'b0;
    endtask

    task automatic send_bits(input int n, input bit with_sof);
        for (int i = 0; i < n; i++) begin
            SIV = 1'b1;
            SOF = with_sof && (i == 0);
            SI  = 1'($urandom_range(0, 1));
            cyc();
        end
        SIV = 1'b0;
        SOF = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0;
        repeat (3) cyc();
        mon_en = 1'b1;
        check("rst_po", 32'(po_m), 32'h0);
        check("rst_pov", 32'(pov_m), 32'h0);
        check("rst_ovr", 32'(ovr_m), 32'h0);
        check("rst_perr", 32'(perr_m), 32'h0);
        RSTN = 1'b1;
        cyc();

        POR = 1'b1;
        send_word(8'hA5, 0, -1, 1'b0, 1'b0);
        idle(4);
        send_word(8'h3C, 3, -1, 1'b0, 1'b0);
        idle(3);

        POR = 1'b0;
        send_word(8'h11, 0, -1, 1'b0, 1'b0);
        send_word(8'h22, 0, -1, 1'b0, 1'b0);
        idle(2);
        check("ovr_set", 32'(ovr_m), 32'h1);
        check("po_held", 32'(po_m), 32'h11);
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        check("ovr_clr", 32'(ovr_m), 32'h0);
        send_word(8'h55, 0, -1, 1'b1, 1'b0);
        idle(1);
        check("ovr_set_wins", 32'(ovr_m), 32'h1);
        POR = 1'b1;
        idle(2);

        POR = 1'b0;
        CLR = 1'b1;
        send_word(8'h33, 0, -1, 1'b0, 1'b0);
        CLR = 1'b0;
        idle(2);
        send_word(8'h44, 1, 1, 1'b0, 1'b0);
        idle(1);
        check("hs_po", 32'(po_m), 32'h44);
        check("hs_ovr", 32'(ovr_m), 32'h0);
        POR = 1'b1;
        idle(2);

        send_bits(5, 1'b1);
        send_word(8'hC3, 0, -1, 1'b0, 1'b0);
        idle(2);

        send_bits(4, 1'b1);
        RSTN = 1'b0;
        cyc();
        check("mid_rst_po", 32'(po_m), 32'h0);
        check("mid_rst_pov", 32'(pov_m), 32'h0);
        check("mid_rst_ovr", 32'(ovr_m), 32'h0);
        RSTN = 1'b1;
        send_bits(W + 2, 1'b0);
        idle(3);
        send_word(8'h5A, 0, -1, 1'b0, 1'b0);
        idle(2);

        send_word(8'hA5, 0, -1, 1'b0, 1'b0);
        idle(2);
        send_word(8'hA5, 2, -1, 1'b0, 1'b1);
        idle(2);

        rand_mode = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) send_bits($urandom_range(1, W - 1), 1'b1);
            send_word(W'($urandom), $urandom_range(0, 3), -1, 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) gap_cycles($urandom_range(1, 3));
        end
        rand_mode = 1'b0;
        POR = 1'b1;
        CLR = 1'b0;
        idle(5);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
